// File: rtl/l1_mem_port_arbiter.sv
// l1_mem_port_arbiter
//   Moves whole cache lines between the two L1 caches and a single
//   system-memory port. The I$ can only fill lines; the D$ can fill lines
//   or write back lines. When both caches ask on the same edge, the one that
//   was not served last time goes first. Every port uses a req/ack handshake.
//
// Ports
//   clk_in, reset_in          clock, synchronous active-high reset
//   ic_req, ic_addr           I$ line-fill request and line address
//   ic_ack, ic_rd_data        one-cycle completion pulse, fill data
//   dc_req, dc_rw, dc_addr,   D$ request, direction (0=fill, 1=write-back),
//   dc_wr_data                line address and write-back data
//   dc_ack, dc_rd_data        one-cycle completion pulse, fill data
//   sm_req, sm_rw, sm_addr,   system-memory request, direction, address,
//   sm_wr_data                write data (held until sm_ack)
//   sm_ack, sm_rd_data        memory completion pulse and read data
//
// All outputs are registered. rd_data outputs keep their value after ack
// falls and only change when their own requester completes a read.

module l1_mem_port_arbiter #(
  parameter int A_SZ   = 32,
  parameter int CL_LEN = 256
) (
  input  logic              clk_in,
  input  logic              reset_in,

  input  logic              ic_req,
  input  logic [A_SZ-1:0]   ic_addr,
  output logic              ic_ack,
  output logic [CL_LEN-1:0] ic_rd_data,

  input  logic              dc_req,
  input  logic              dc_rw,
  input  logic [A_SZ-1:0]   dc_addr,
  input  logic [CL_LEN-1:0] dc_wr_data,
  output logic              dc_ack,
  output logic [CL_LEN-1:0] dc_rd_data,

  output logic              sm_req,
  output logic              sm_rw,
  output logic [A_SZ-1:0]   sm_addr,
  output logic [CL_LEN-1:0] sm_wr_data,
  input  logic              sm_ack,
  input  logic [CL_LEN-1:0] sm_rd_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IC_XFER = 2'd1,
    DC_XFER = 2'd2
  } state_e;

  typedef enum logic {
    GRANT_IC = 1'b0,
    GRANT_DC = 1'b1
  } grant_e;

  state_e state;
  grant_e last_grant;

  // D$ wins when it is the only requester, or on a tie when the I$ was
  // served last. Otherwise the I$ wins if it is asking at all.
  logic pick_dc;
  assign pick_dc = dc_req && (!ic_req || (last_grant == GRANT_IC));

  // NOTE: all state and outputs are updated with non-blocking assignments so
  // that every register sees the pre-edge values of its neighbours.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      // NOTE: the line-wide data registers are cleared too, because every
      // output must read zero after reset, not just the control bits.
      state      <= IDLE;
      last_grant <= GRANT_IC;
      ic_ack     <= 1'b0;
      dc_ack     <= 1'b0;
      ic_rd_data <= '0;
      dc_rd_data <= '0;
      sm_req     <= 1'b0;
      sm_rw      <= 1'b0;
      sm_addr    <= '0;
      sm_wr_data <= '0;
    end else begin
      // Acks are single-cycle pulses; only a completing edge raises one.
      ic_ack <= 1'b0;
      dc_ack <= 1'b0;

      case (state)
        IDLE: begin
          // sm_ack seen here belongs to no transaction and is ignored.
          if (pick_dc) begin
            sm_req     <= 1'b1;
            sm_rw      <= dc_rw;
            sm_addr    <= dc_addr;
            sm_wr_data <= dc_wr_data;
            last_grant <= GRANT_DC;
            state      <= DC_XFER;
          end else if (ic_req) begin
            sm_req     <= 1'b1;
            sm_rw      <= 1'b0;
            sm_addr    <= ic_addr;
            sm_wr_data <= '0;
            last_grant <= GRANT_IC;
            state      <= IC_XFER;
          end
        end

        IC_XFER: begin
          if (sm_ack) begin
            sm_req     <= 1'b0;
            ic_ack     <= 1'b1;
            ic_rd_data <= sm_rd_data;
            state      <= IDLE;
          end
        end

        DC_XFER: begin
          if (sm_ack) begin
            sm_req <= 1'b0;
            dc_ack <= 1'b1;
            // A write-back returns no data; keep the last fill visible.
            if (!sm_rw) begin
              dc_rd_data <= sm_rd_data;
            end
            state <= IDLE;
          end
        end

        default: begin
          state  <= IDLE;
          sm_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_mem_port_arbiter.sv
// Directed bench for l1_mem_port_arbiter. Inputs change 1 ns after the
// rising edge and outputs are read at the same point, well away from the
// edge that samples them.

module tb_l1_mem_port_arbiter;

  localparam int A_SZ   = 32;
  localparam int CL_LEN = 256;

  localparam logic [CL_LEN-1:0] PAT_A = {8{32'hA5A5_0001}};
  localparam logic [CL_LEN-1:0] PAT_B = {8{32'hB00B_0002}};
  localparam logic [CL_LEN-1:0] PAT_C = {8{32'hC3C3_0003}};
  localparam logic [CL_LEN-1:0] PAT_D = {8{32'hD00D_0004}};
  localparam logic [CL_LEN-1:0] PAT_E = {8{32'hE1E1_0005}};
  localparam logic [CL_LEN-1:0] PAT_F = {8{32'hF0F0_0006}};

  logic              clk_in = 1'b0;
  logic              reset_in;
  logic              ic_req;
  logic [A_SZ-1:0]   ic_addr;
  logic              ic_ack;
  logic [CL_LEN-1:0] ic_rd_data;
  logic              dc_req;
  logic              dc_rw;
  logic [A_SZ-1:0]   dc_addr;
  logic [CL_LEN-1:0] dc_wr_data;
  logic              dc_ack;
  logic [CL_LEN-1:0] dc_rd_data;
  logic              sm_req;
  logic              sm_rw;
  logic [A_SZ-1:0]   sm_addr;
  logic [CL_LEN-1:0] sm_wr_data;
  logic              sm_ack;
  logic [CL_LEN-1:0] sm_rd_data;

  int n_checks = 0;
  int n_errors = 0;

  l1_mem_port_arbiter #(.A_SZ(A_SZ), .CL_LEN(CL_LEN)) dut (
    .clk_in     (clk_in),
    .reset_in   (reset_in),
    .ic_req     (ic_req),
    .ic_addr    (ic_addr),
    .ic_ack     (ic_ack),
    .ic_rd_data (ic_rd_data),
    .dc_req     (dc_req),
    .dc_rw      (dc_rw),
    .dc_addr    (dc_addr),
    .dc_wr_data (dc_wr_data),
    .dc_ack     (dc_ack),
    .dc_rd_data (dc_rd_data),
    .sm_req     (sm_req),
    .sm_rw      (sm_rw),
    .sm_addr    (sm_addr),
    .sm_wr_data (sm_wr_data),
    .sm_ack     (sm_ack),
    .sm_rd_data (sm_rd_data)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [CL_LEN-1:0] got,
                       input logic [CL_LEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Bounded wait for the memory request to appear.
  task automatic wait_sm_req(output bit ok);
    int n = 0;
    while (!sm_req && n < 10) begin
      tick();
      n++;
    end
    ok = sm_req;
  endtask

  bit ok;
  bit exp_dc;

  initial begin
    reset_in   = 1'b1;
    ic_req     = 1'b0;
    ic_addr    = '0;
    dc_req     = 1'b0;
    dc_rw      = 1'b0;
    dc_addr    = '0;
    dc_wr_data = '0;
    sm_ack     = 1'b0;
    sm_rd_data = '0;
    tick();
    tick();

    // Reset state: every output is zero.
    check("rst_sm_req", sm_req, 0);
    check("rst_sm_rw", sm_rw, 0);
    check("rst_sm_addr", sm_addr, 0);
    check("rst_sm_wr_data", sm_wr_data, 0);
    check("rst_ic_ack", ic_ack, 0);
    check("rst_dc_ack", dc_ack, 0);
    check("rst_ic_rd_data", ic_rd_data, 0);
    check("rst_dc_rd_data", dc_rd_data, 0);
    reset_in = 1'b0;
    tick();

    // ---- I$ only fill ----
    ic_req  = 1'b1;
    ic_addr = 32'h0000_0100;
    check("ic_pre_sm_req", sm_req, 0);
    tick();
    check("ic_sm_req", sm_req, 1);
    check("ic_sm_rw", sm_rw, 0);
    check("ic_sm_addr", sm_addr, 32'h100);
    check("ic_sm_wr_data", sm_wr_data, 0);
    tick();
    tick();
    check("ic_hold_sm_req", sm_req, 1);
    check("ic_hold_ack", ic_ack, 0);
    sm_ack     = 1'b1;
    sm_rd_data = PAT_A;
    tick();
    sm_ack = 1'b0;
    check("ic_ack_pulse", ic_ack, 1);
    check("ic_rd_data", ic_rd_data, PAT_A);
    check("ic_no_dc_ack", dc_ack, 0);
    check("ic_sm_req_drop", sm_req, 0);
    ic_req = 1'b0;
    tick();
    check("ic_ack_fall", ic_ack, 0);
    check("ic_rd_data_keep", ic_rd_data, PAT_A);
    check("ic_idle_sm_req", sm_req, 0);

    // ---- D$ write-back ----
    dc_req     = 1'b1;
    dc_rw      = 1'b1;
    dc_addr    = 32'h0000_2000;
    dc_wr_data = PAT_B;
    tick();
    check("dcw_sm_req", sm_req, 1);
    check("dcw_sm_rw", sm_rw, 1);
    check("dcw_sm_addr", sm_addr, 32'h2000);
    check("dcw_sm_wr_data", sm_wr_data, PAT_B);
    tick();
    sm_ack     = 1'b1;
    sm_rd_data = PAT_C;
    tick();
    sm_ack = 1'b0;
    check("dcw_ack_pulse", dc_ack, 1);
    check("dcw_rd_data_keep", dc_rd_data, 0);
    check("dcw_no_ic_ack", ic_ack, 0);
    check("dcw_ic_rd_keep", ic_rd_data, PAT_A);
    dc_req = 1'b0;
    tick();
    check("dcw_ack_fall", dc_ack, 0);

    // ---- Tie right after reset: D$ first, then I$ ----
    reset_in = 1'b1;
    tick();
    reset_in   = 1'b0;
    ic_req     = 1'b1;
    ic_addr    = 32'h0000_0400;
    dc_req     = 1'b1;
    dc_rw      = 1'b0;
    dc_addr    = 32'h0000_3000;
    dc_wr_data = PAT_F;
    tick();
    check("tie_sm_req", sm_req, 1);
    check("tie_first_addr", sm_addr, 32'h3000);
    check("tie_first_rw", sm_rw, 0);
    sm_ack     = 1'b1;
    sm_rd_data = PAT_D;
    tick();
    sm_ack = 1'b0;
    check("tie_dc_ack", dc_ack, 1);
    check("tie_dc_rd", dc_rd_data, PAT_D);
    check("tie_ic_wait", ic_ack, 0);
    check("tie_gap_sm_req", sm_req, 0);
    dc_req = 1'b0;
    tick();
    check("tie_ic_sm_req", sm_req, 1);
    check("tie_ic_addr", sm_addr, 32'h400);
    check("tie_ic_rw", sm_rw, 0);
    sm_ack     = 1'b1;
    sm_rd_data = PAT_E;
    tick();
    sm_ack = 1'b0;
    check("tie_ic_ack", ic_ack, 1);
    check("tie_ic_rd", ic_rd_data, PAT_E);
    check("tie_dc_rd_keep", dc_rd_data, PAT_D);
    ic_req = 1'b0;
    tick();

    // ---- Round robin with both caches re-requesting (last served: I$) ----
    ic_addr = 32'h0000_0500;
    dc_addr = 32'h0000_6000;
    dc_rw   = 1'b0;
    ic_req  = 1'b1;
    dc_req  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_dc = (i % 2 == 0);
      wait_sm_req(ok);
      check("rr_sm_req", {255'd0, ok}, 1);
      check("rr_addr", sm_addr, exp_dc ? 32'h6000 : 32'h500);
      sm_ack     = 1'b1;
      sm_rd_data = {8{32'h0000_00A0 + i}};
      tick();
      sm_ack = 1'b0;
      check("rr_dc_ack", dc_ack, exp_dc);
      check("rr_ic_ack", ic_ack, !exp_dc);
      if (dc_ack) dc_req = 1'b0;
      if (ic_ack) ic_req = 1'b0;
      tick();
      ic_req = 1'b1;
      dc_req = 1'b1;
    end

    // ---- Reset in the middle of the D$ transfer just granted ----
    check("mid_sm_req", sm_req, 1);
    check("mid_sm_addr", sm_addr, 32'h6000);
    reset_in = 1'b1;
    tick();
    check("mid_rst_sm_req", sm_req, 0);
    check("mid_rst_ic_ack", ic_ack, 0);
    check("mid_rst_dc_ack", dc_ack, 0);
    reset_in = 1'b0;
    ic_req   = 1'b0;
    dc_req   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_sm_req", sm_req, 0);
      check("post_rst_acks", {ic_ack, dc_ack}, 0);
    end

    // ---- Spurious sm_ack in IDLE ----
    sm_ack     = 1'b1;
    sm_rd_data = PAT_F;
    tick();
    sm_ack = 1'b0;
    check("spur_ic_ack", ic_ack, 0);
    check("spur_dc_ack", dc_ack, 0);
    check("spur_ic_rd", ic_rd_data, 0);
    check("spur_dc_rd", dc_rd_data, 0);
    check("spur_sm_req", sm_req, 0);

    // ---- sm_ack on the grant edge is ignored ----
    ic_req     = 1'b1;
    ic_addr    = 32'h0000_0700;
    sm_ack     = 1'b1;
    sm_rd_data = PAT_B;
    tick();
    sm_ack = 1'b0;
    check("grant_ack_sm_req", sm_req, 1);
    check("grant_ack_ic_ack", ic_ack, 0);
    tick();
    check("grant_ack_hold", sm_req, 1);
    check("grant_ack_no_ack", ic_ack, 0);
    sm_ack     = 1'b1;
    sm_rd_data = PAT_C;
    tick();
    sm_ack = 1'b0;
    check("grant_ack_done", ic_ack, 1);
    check("grant_ack_rd", ic_rd_data, PAT_C);
    ic_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/l1_mem_port_arbiter.md
Name: l1_mem_port_arbiter

Overview:
- Arbitrates cache-line transfers from the L1 instruction cache (read-only) and the L1 data cache (read or write-back) onto one system-memory port.
- Sits between the L1 I$/D$ arbiter-side ports and system memory.
- Serves one full cache line per transaction.
- Uses a req/ack handshake on every port, with round-robin fairness between the two caches.

Parameters:
- A_SZ, 32, byte-address width on all ports.
- CL_LEN, 256, cache-line width in bits on all data buses.

Ports:
- clk_in  input  1  system clock.
- reset_in  input  1  synchronous, active-high reset.
- ic_req  input  1  I$ line-fill request.
- ic_addr  input  A_SZ  I$ line address (line-aligned).
- ic_ack  output  1  one-cycle pulse: I$ fill complete.
- ic_rd_data  output  CL_LEN  fill data, valid while ic_ack=1.
- dc_req  input  1  D$ request.
- dc_rw  input  1  D$ direction: 0=line read (fill), 1=line write (write-back).
- dc_addr  input  A_SZ  D$ line address.
- dc_wr_data  input  CL_LEN  D$ write-back data.
- dc_ack  output  1  one-cycle pulse: D$ transfer complete.
- dc_rd_data  output  CL_LEN  fill data, valid while dc_ack=1 and dc_rw=0.
- sm_req  output  1  system-memory request.
- sm_rw  output  1  0=read, 1=write.
- sm_addr  output  A_SZ  system-memory line address.
- sm_wr_data  output  CL_LEN  system-memory write data.
- sm_ack  input  1  one-cycle pulse: memory transfer complete.
- sm_rd_data  input  CL_LEN  memory read data, valid with sm_ack.

Behaviour:
- States: IDLE, IC_XFER, DC_XFER. All outputs are registered.
- Reset: state=IDLE, last_grant=IC; every output = 0. Reset mid-transfer abandons the transaction, and sm_req is 0 in the cycle after the reset edge.
- Requester rules:
  - A requester holds req, addr, rw and wr_data stable until it samples its ack=1.
  - It drops req on that same edge, so req is low in the cycle after ack.
- IDLE, arbitration at a clock edge:
  - If only one req=1, grant that requester.
  - If both req=1, grant the requester that was not last_grant. After reset, DC therefore wins the first tie.
  - If neither req=1, stay in IDLE.
- On grant:
  - Latch the granted requester's address into sm_addr.
  - For DC: sm_rw=dc_rw and sm_wr_data=dc_wr_data.
  - For IC: sm_rw=0 and sm_wr_data=0.
  - Set sm_req=1, update last_grant, and enter IC_XFER or DC_XFER.
- sm_req is first visible in the cycle after the edge where req was sampled (1-cycle request latency).
- XFER states:
  - Hold sm_req and all sm_* outputs constant until an edge where sm_ack=1.
  - On that edge: sm_req←0, and the granted requester's ack←1 for exactly one cycle.
  - For a read, the granted requester's rd_data←sm_rd_data on the same edge. For a D$ write, dc_rd_data is unchanged.
  - Return to IDLE.
- The requester that was not granted receives no ack and its rd_data does not change.
- rd_data outputs keep their last value after ack falls.
- In IDLE, the cycle after an ack, the just-served requester's req is already low. A newly granted transaction's sm_req therefore rises no earlier than 2 cycles after the previous sm_ack edge.
- sm_ack asserted while in IDLE is ignored.
- sm_ack asserted on the same edge as a grant (state IDLE) is ignored.
- Maximum sm_ack wait is unbounded; the arbiter has no timeout.

Test Plan:
- IC only: ic_req=1 with ic_addr=0x0000_0100; sm_ack after 3 cycles with sm_rd_data=pattern A. Required: sm_req=1, sm_rw=0, sm_addr=0x100 the cycle after request; ic_ack pulses 1 cycle with ic_rd_data=A; dc_ack stays 0.
- DC write-back: dc_req=1, dc_rw=1, dc_addr=0x2000, dc_wr_data=B. Required: sm_rw=1, sm_addr=0x2000, sm_wr_data=B; dc_ack pulses once after sm_ack.
- Simultaneous requests right after reset: ic_req=dc_req=1. Required: DC served first. IC served next; its sm_req rises 2 cycles after the DC sm_ack edge, with sm_addr=ic_addr.
- Round-robin: keep both caches re-requesting for 4 transactions. Required: grant order DC, IC, DC, IC.
- Reset mid-operation: assert reset_in during DC_XFER. Required: the cycle after the reset edge, sm_req=0 and all acks=0; after reset release with no requests, state stays IDLE and no ack appears.
- Spurious sm_ack in IDLE: pulse sm_ack with no request pending. Required: no ic_ack or dc_ack, and rd_data outputs unchanged.
